// File: rtl/serial_alu_pkg.sv
// Shared types for the serial ALU engine: FSM states, opcodes, parameter check.
// Combinational only. No handshake.
// No backpressure.
package serial_alu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_EXEC  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        OP_MASKOR = 3'd0,
        OP_XORADD = 3'd1,
        OP_ABSXOR = 3'd2,
        OP_MINLO  = 3'd3,
        OP_MAXSHL = 3'd4,
        OP_SATAND = 3'd5,
        OP_AVGOR  = 3'd6,
        OP_ROTX   = 3'd7
    } op_t;

    // N must split into at least two whole W-bit beats.
    function automatic bit beats_ok(input int n, input int w);
        if (w <= 0) return 1'b0;
        return ((n % w) == 0) && ((n / w) >= 2);
    endfunction

endpackage

// File: rtl/serial_alu_ops.sv
// Next-accumulator function for all eight opcodes.
// Purely combinational, zero cycles.
// No handshake; the caller decides when to capture next_acc.
module serial_alu_ops
    import serial_alu_pkg::*;
#(
    parameter int N = 64
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [N-1:0] acc,
    input  logic [2:0]   op,
    output logic [N-1:0] next_acc
);

    logic         a_lt_b;
    logic [N-1:0] min_ab;
    logic [N-1:0] max_ab;
    logic [N-1:0] abs_diff;
    logic [N:0]   sum_ext;
    logic [N-1:0] sat_sum;
    logic [N-1:0] avg_ab;
    logic [N-1:0] rot_a;

    assign a_lt_b   = a < b;
    assign min_ab   = a_lt_b ? a : b;
    assign max_ab   = a_lt_b ? b : a;
    assign abs_diff = a_lt_b ? (b - a) : (a - b);
    assign sum_ext  = {1'b0, a} + {1'b0, b};
    assign sat_sum  = sum_ext[N] ? {N{1'b1}} : sum_ext[N-1:0];
    // Halving the xor term keeps the average inside N bits.
    assign avg_ab   = (a & b) + ((a ^ b) >> 1);
    assign rot_a    = {a[N-2:0], a[N-1]};

    always_comb begin
        next_acc = acc;
        case (op_t'(op))
            OP_MASKOR: next_acc = (a & b) | acc;
            OP_XORADD: next_acc = (a ^ b) + acc;
            OP_ABSXOR: next_acc = abs_diff ^ acc;
            OP_MINLO:  next_acc = {acc[N-1:N/2], min_ab[N/2-1:0]};
            OP_MAXSHL: next_acc = max_ab + (acc << 1);
            OP_SATAND: next_acc = sat_sum & acc;
            OP_AVGOR:  next_acc = avg_ab | acc;
            OP_ROTX:   next_acc = rot_a ^ b ^ acc;
            default:   next_acc = acc;
        endcase
    end

endmodule

// File: rtl/serial_alu_engine.sv
// Serial ALU: W-bit operand load, opcode stream on an N-bit accumulator, W-bit drain.
// Latency: BEATS load cycles + one per op + BEATS drain cycles; acc updates one cycle after an op.
// Every phase is valid/ready, any stall holds state. SERIAL_ALU_OPCOUNT_EN adds op_count.
module serial_alu_engine
    import serial_alu_pkg::*;
#(
    parameter int N = 64,
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a_in,
    input  logic [W-1:0] b_in,
    input  logic         op_valid,
    output logic         op_ready,
    input  logic [2:0]   op_code,
    input  logic         op_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
`ifdef SERIAL_ALU_OPCOUNT_EN
    output logic [7:0]   op_count,
`endif
    output logic [1:0]   state_o
);

    localparam int BEATS = N / W;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    generate
        if (!beats_ok(N, W)) begin : g_param_err
            $error("serial_alu_engine: N must be a multiple of W with N/W >= 2");
        end
    endgenerate

    state_t        state_q, state_d;
    logic [BW-1:0] beat_q, beat_d;
    logic [N-1:0]  a_q, a_d;
    logic [N-1:0]  b_q, b_d;
    logic [N-1:0]  acc_q, acc_d;
    logic [N-1:0]  next_acc;

    serial_alu_ops #(.N(N)) u_ops (
        .a        (a_q),
        .b        (b_q),
        .acc      (acc_q),
        .op       (op_code),
        .next_acc (next_acc)
    );

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    beat_d  = '0;
                    a_d     = '0;
                    b_d     = '0;
                    acc_d   = '0;
                end
            end
            ST_LOAD: begin
                if (in_valid) begin
                    a_d[beat_q*W +: W] = a_in;
                    b_d[beat_q*W +: W] = b_in;
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = '0;
                        state_d = ST_EXEC;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            ST_EXEC: begin
                if (op_valid) begin
                    acc_d = next_acc;
                    if (op_last) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (out_ready) begin
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = '0;
                        state_d = ST_IDLE;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            beat_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
        end
    end

    assign in_ready  = (state_q == ST_LOAD);
    assign op_ready  = (state_q == ST_EXEC);
    assign out_valid = (state_q == ST_DRAIN);
    assign out_data  = (state_q == ST_DRAIN) ? acc_q[beat_q*W +: W] : '0;
    assign state_o   = state_q;

`ifdef SERIAL_ALU_OPCOUNT_EN
    logic [7:0] op_cnt_q, op_cnt_d;

    always_comb begin
        op_cnt_d = op_cnt_q;
        if (state_q == ST_IDLE && start) begin
            op_cnt_d = '0;
        end else if (state_q == ST_EXEC && op_valid && op_cnt_q != 8'hFF) begin
            op_cnt_d = op_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) op_cnt_q <= '0;
        else     op_cnt_q <= op_cnt_d;
    end

    assign op_count = op_cnt_q;
`endif

endmodule
